tx_data_mac: RTL and testbench
==============================

Name: tx_data_mac

Overview:
- Transmit-side framer for the FPGA client; the counterpart of the receive parser.
- Builds complete Ethernet II frames for two cases: IPv4/UDP datagrams carrying upstream payload, and ARP replies to requests flagged by the receive side.
- Drives the MAC's 8-bit LocalLink TX interface, which uses active-low framing and handshake signals.
- The MAC appends preamble and FCS. This block pads frames to the 60-byte minimum.

Parameters:
- SRC_MAC, 48'h0023551C3564, own MAC address.
- SRC_IP, 32'hA9FEF298, own IPv4 address (169.254.242.152).
- SRC_PORT, 16'h11D2, UDP source port.
- TTL, 8'h40, IPv4 time-to-live.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- send_udp  in  1  request a UDP frame; sampled in IDLE only.
- send_arp  in  1  request an ARP reply; sampled in IDLE only.
- dst_mac  in  48  destination MAC for UDP.
- dst_ip  in  32  destination IP for UDP.
- dst_port  in  16  UDP destination port.
- payload_len  in  11  UDP payload byte count, valid range 0..1472.
- arp_mac  in  48  requester MAC, from the receive side.
- arp_ip  in  32  requester IP, from the receive side.
- payload_data  in  8  payload byte from a first-word-fall-through FIFO.
- payload_rd  out  1  FIFO pop; high in the cycle the current payload byte is transferred.
- tx_data  out  8  frame byte.
- tx_sof  out  1  active-low start of frame.
- tx_eof  out  1  active-low end of frame.
- tx_src_rdy  out  1  active-low, tx_data valid.
- tx_dst_rdy  in  1  active-low, MAC accepts the byte.
- busy  out  1  high from request acceptance to the end of DONE.
- done  out  1  one-cycle pulse after the last byte is transferred.
- tx_error  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset values: tx_sof, tx_eof and tx_src_rdy are 1; tx_data is 0; payload_rd, busy, done and tx_error are 0; the IP identification counter is 0; state is IDLE.
- Transfer rule: a byte moves only in a cycle where tx_src_rdy=0 and tx_dst_rdy=0. Otherwise tx_data, tx_sof and tx_eof hold.
- Request acceptance (IDLE only):
  - If send_arp and send_udp are both high, ARP wins and the UDP request is dropped.
  - A UDP request with payload_len>1472 pulses tx_error and stays in IDLE.
  - On acceptance, all inputs are latched and busy rises.
  - Requests arriving while busy are ignored.
- States and transitions:
  - IDLE -> CSUM on acceptance.
  - CSUM lasts 2 cycles.
  - CSUM -> HDR.
  - HDR -> PAYLOAD when payload_len>0, otherwise -> PAD or LAST.
  - PAYLOAD -> PAD or LAST.
  - Frame end -> DONE, 1 cycle, which pulses done.
  - DONE -> IDLE.
- Latency: with send_udp or send_arp accepted at edge T, tx_src_rdy goes low and tx_sof goes low with byte 0 after edge T+3.
- tx_sof is low for byte 0 only. tx_eof is low for the final byte only. tx_src_rdy stays low continuously through the frame.
- UDP frame byte order:
  - dst_mac, SRC_MAC, 08 00.
  - IPv4 header: 45 00, total_len=28+N, ident, 00 00, TTL, 11, hdr_csum, SRC_IP, dst_ip.
  - UDP header: SRC_PORT, dst_port, udp_len=8+N, 00 00 (checksum disabled).
  - N payload bytes.
- IP header checksum:
  - 32-bit sum of the ten header 16-bit words, with the checksum word taken as 0.
  - Fold carries twice, then ones-complement; transmit MSB first.
  - Computed entirely in CSUM.
- ident increments by 1 (wrapping 16 bits) after each completed UDP frame. It does not increment for ARP frames or aborted frames.
- ARP reply byte order:
  - arp_mac, SRC_MAC, 08 06.
  - 00 01 08 00 06 04 00 02.
  - SRC_MAC, SRC_IP, arp_mac, arp_ip.
- Padding: frames shorter than 60 bytes are padded with 00 up to byte 59. This applies to UDP with N<18 and to every ARP reply (42 bytes, plus 18 pad). tx_eof is on byte 59.
- Payload handling: payload_rd is high exactly in the cycles where a PAYLOAD byte transfers. It is never high during stalls. There are no lookahead reads.
- The byte counter is 11 bits. The maximum frame is 14+28+1472 = 1514 bytes.
- Reset asserted mid-frame: all outputs immediately take their reset values. The frame is truncated with no eof; the MAC discards it. ident is reset.

Test Plan:
- UDP, N=6, dst_ip A9FEF299, dst_port 11D2, ident 0, tx_dst_rdy held 0 → 60-byte frame. Byte 12..13 = 08 00; total_len 00 22; hdr_csum 41 9C; udp_len 00 0E; 6 payload bytes then 12 pad bytes. sof on byte 0, eof on byte 59, 6 payload_rd pulses, done once, ident becomes 1.
- ARP reply with arp_mac 24 24 24 24 24 24 and arp_ip A9FEF299 → 60 bytes. Byte 12..21 = 08 06 00 01 08 00 06 04 00 02; target fields match the inputs; bytes 42..59 = 00. ident unchanged.
- Backpressure: tx_dst_rdy pseudo-random 50% during a UDP N=100 frame → byte sequence identical to the unstalled run; exactly 100 payload_rd pulses; tx_data stable during stalls.
- send_arp and send_udp in the same cycle → ARP frame only; a later send_udp while busy is ignored; busy falls after done.
- payload_len=1473 → one tx_error pulse, no tx_src_rdy activity. Then N=1472 → 1514-byte frame with total_len 05 DC.
- reset asserted at byte 20 of a frame → next cycle tx_src_rdy=1 and busy=0; a new request afterwards sends ident 0.

Source files
------------

// File: rtl/tx_data_mac.sv
// Transmit framer: builds Ethernet II frames (IPv4/UDP or ARP reply) onto an
// 8-bit active-low LocalLink TX interface, padding short frames to 60 bytes.
module tx_data_mac #(
  parameter logic [47:0] SRC_MAC  = 48'h0023551C3564,
  parameter logic [31:0] SRC_IP   = 32'hA9FEF298,
  parameter logic [15:0] SRC_PORT = 16'h11D2,
  parameter logic [7:0]  TTL      = 8'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send_udp,
  input  logic        send_arp,
  input  logic [47:0] dst_mac,
  input  logic [31:0] dst_ip,
  input  logic [15:0] dst_port,
  input  logic [10:0] payload_len,
  input  logic [47:0] arp_mac,
  input  logic [31:0] arp_ip,
  input  logic [7:0]  payload_data,
  output logic        payload_rd,
  output logic [7:0]  tx_data,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        tx_src_rdy,
  input  logic        tx_dst_rdy,
  output logic        busy,
  output logic        done,
  output logic        tx_error
);

  typedef enum logic [2:0] {IDLE, CSUM, HDR, PAYLOAD, PAD, DONE} state_t;

  localparam logic [10:0] MAX_PAYLOAD = 11'd1472;
  localparam logic [10:0] HDR_BYTES   = 11'd42;

  state_t      state_q, state_d;
  logic        csum_cnt_q, csum_cnt_d;
  logic        is_arp_q, is_arp_d;
  logic [47:0] dst_mac_q, dst_mac_d;
  logic [31:0] dst_ip_q, dst_ip_d;
  logic [15:0] dst_port_q, dst_port_d;
  logic [10:0] len_q, len_d;
  logic [47:0] arp_mac_q, arp_mac_d;
  logic [31:0] arp_ip_q, arp_ip_d;
  logic [15:0] ident_q, ident_d;
  logic [31:0] sum_q, sum_d;
  logic [15:0] csum_q, csum_d;
  logic [10:0] cur_idx_q, cur_idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_sof_q, tx_sof_d;
  logic        tx_eof_q, tx_eof_d;
  logic        tx_src_rdy_q, tx_src_rdy_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tx_error_q, tx_error_d;

  logic         xfer;
  logic [15:0]  total_len, udp_len;
  logic [10:0]  last_idx, pay_end, next_idx, sel_idx;
  logic [5:0]   hdr_sel;
  logic [8:0]   hdr_shift;
  logic [335:0] hdr_vec;
  logic [7:0]   hdr_byte;
  logic [16:0]  fold1;
  logic [15:0]  fold2;

  assign xfer      = !tx_src_rdy_q && !tx_dst_rdy;
  assign total_len = 16'd28 + {5'd0, len_q};
  assign udp_len   = 16'd8 + {5'd0, len_q};
  assign last_idx  = (len_q < 11'd18) ? 11'd59 : (11'd41 + len_q);
  assign pay_end   = HDR_BYTES + len_q;
  assign next_idx  = cur_idx_q + 11'd1;

  // The first header byte is loaded from HDR while src_rdy is still high.
  assign sel_idx   = tx_src_rdy_q ? 11'd0 : next_idx;
  assign hdr_sel   = (sel_idx < HDR_BYTES) ? sel_idx[5:0] : 6'd0;
  assign hdr_shift = {3'd0, 6'd41 - hdr_sel} << 3;
  assign hdr_byte  = hdr_vec[hdr_shift +: 8];

  always_comb begin
    hdr_vec = '0;
    if (is_arp_q) begin
      hdr_vec = {arp_mac_q, SRC_MAC, 16'h0806, 64'h0001_0800_0604_0002,
                 SRC_MAC, SRC_IP, arp_mac_q, arp_ip_q};
    end else begin
      hdr_vec = {dst_mac_q, SRC_MAC, 16'h0800, 16'h4500, total_len, ident_q,
                 16'h0000, TTL, 8'h11, csum_q, SRC_IP, dst_ip_q,
                 SRC_PORT, dst_port_q, udp_len, 16'h0000};
    end
  end

  assign fold1 = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

  assign payload_rd = xfer && (state_q == PAYLOAD);
  assign tx_data    = (state_q == PAYLOAD) ? payload_data : tx_data_q;
  assign tx_sof     = tx_sof_q;
  assign tx_eof     = tx_eof_q;
  assign tx_src_rdy = tx_src_rdy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tx_error   = tx_error_q;

  always_comb begin
    state_d      = state_q;
    csum_cnt_d   = csum_cnt_q;
    is_arp_d     = is_arp_q;
    dst_mac_d    = dst_mac_q;
    dst_ip_d     = dst_ip_q;
    dst_port_d   = dst_port_q;
    len_d        = len_q;
    arp_mac_d    = arp_mac_q;
    arp_ip_d     = arp_ip_q;
    ident_d      = ident_q;
    sum_d        = sum_q;
    csum_d       = csum_q;
    cur_idx_d    = cur_idx_q;
    tx_data_d    = tx_data_q;
    tx_sof_d     = tx_sof_q;
    tx_eof_d     = tx_eof_q;
    tx_src_rdy_d = tx_src_rdy_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    tx_error_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (send_arp) begin
          is_arp_d   = 1'b1;
          arp_mac_d  = arp_mac;
          arp_ip_d   = arp_ip;
          dst_mac_d  = dst_mac;
          dst_ip_d   = dst_ip;
          dst_port_d = dst_port;
          len_d      = 11'd0;
          busy_d     = 1'b1;
          csum_cnt_d = 1'b0;
          state_d    = CSUM;
        end else if (send_udp) begin
          if (payload_len > MAX_PAYLOAD) begin
            tx_error_d = 1'b1;
          end else begin
            is_arp_d   = 1'b0;
            arp_mac_d  = arp_mac;
            arp_ip_d   = arp_ip;
            dst_mac_d  = dst_mac;
            dst_ip_d   = dst_ip;
            dst_port_d = dst_port;
            len_d      = payload_len;
            busy_d     = 1'b1;
            csum_cnt_d = 1'b0;
            state_d    = CSUM;
          end
        end
      end

      CSUM: begin
        if (!csum_cnt_q) begin
          sum_d = 32'h0000_4500 + {16'd0, total_len} + {16'd0, ident_q}
                + {16'd0, TTL, 8'h11}
                + {16'd0, SRC_IP[31:16]} + {16'd0, SRC_IP[15:0]}
                + {16'd0, dst_ip_q[31:16]} + {16'd0, dst_ip_q[15:0]};
          csum_cnt_d = 1'b1;
        end else begin
          csum_d  = ~fold2;
          state_d = HDR;
        end
      end

      HDR, PAYLOAD, PAD: begin
        if ((state_q == HDR) && tx_src_rdy_q) begin
          tx_data_d    = hdr_byte;
          tx_sof_d     = 1'b0;
          tx_eof_d     = 1'b1;
          tx_src_rdy_d = 1'b0;
          cur_idx_d    = 11'd0;
        end else if (xfer) begin
          if (cur_idx_q == last_idx) begin
            state_d      = DONE;
            tx_src_rdy_d = 1'b1;
            tx_sof_d     = 1'b1;
            tx_eof_d     = 1'b1;
            done_d       = 1'b1;
          end else begin
            cur_idx_d = next_idx;
            tx_sof_d  = 1'b1;
            tx_eof_d  = (next_idx != last_idx);
            if (next_idx < HDR_BYTES) begin
              state_d   = HDR;
              tx_data_d = hdr_byte;
            end else if (next_idx < pay_end) begin
              state_d = PAYLOAD;
            end else begin
              state_d   = PAD;
              tx_data_d = 8'h00;
            end
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!is_arp_q) ident_d = ident_q + 16'd1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      csum_cnt_q   <= 1'b0;
      is_arp_q     <= 1'b0;
      dst_mac_q    <= '0;
      dst_ip_q     <= '0;
      dst_port_q   <= '0;
      len_q        <= '0;
      arp_mac_q    <= '0;
      arp_ip_q     <= '0;
      ident_q      <= '0;
      sum_q        <= '0;
      csum_q       <= '0;
      cur_idx_q    <= '0;
      tx_data_q    <= '0;
      tx_sof_q     <= 1'b1;
      tx_eof_q     <= 1'b1;
      tx_src_rdy_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tx_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      csum_cnt_q   <= csum_cnt_d;
      is_arp_q     <= is_arp_d;
      dst_mac_q    <= dst_mac_d;
      dst_ip_q     <= dst_ip_d;
      dst_port_q   <= dst_port_d;
      len_q        <= len_d;
      arp_mac_q    <= arp_mac_d;
      arp_ip_q     <= arp_ip_d;
      ident_q      <= ident_d;
      sum_q        <= sum_d;
      csum_q       <= csum_d;
      cur_idx_q    <= cur_idx_d;
      tx_data_q    <= tx_data_d;
      tx_sof_q     <= tx_sof_d;
      tx_eof_q     <= tx_eof_d;
      tx_src_rdy_q <= tx_src_rdy_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tx_error_q   <= tx_error_d;
    end
  end

endmodule

// File: tb/tb_tx_data_mac.sv
// Scoreboard bench for tx_data_mac: expected frame bytes are queued when a
// request is issued and compared byte by byte as the DUT presents them.
module tb_tx_data_mac;

  localparam logic [47:0] SRC_MAC  = 48'h0023551C3564;
  localparam logic [31:0] SRC_IP   = 32'hA9FEF298;
  localparam logic [15:0] SRC_PORT = 16'h11D2;
  localparam logic [7:0]  TTL      = 8'h40;

  logic        clk = 1'b0;
  logic        reset;
  logic        send_udp, send_arp;
  logic [47:0] dst_mac, arp_mac;
  logic [31:0] dst_ip, arp_ip;
  logic [15:0] dst_port;
  logic [10:0] payload_len;
  logic [7:0]  payload_data;
  logic        payload_rd;
  logic [7:0]  tx_data;
  logic        tx_sof, tx_eof, tx_src_rdy, tx_dst_rdy;
  logic        busy, done, tx_error;

  always #5 clk = ~clk;

  tx_data_mac dut (
    .clk(clk), .reset(reset), .send_udp(send_udp), .send_arp(send_arp),
    .dst_mac(dst_mac), .dst_ip(dst_ip), .dst_port(dst_port),
    .payload_len(payload_len), .arp_mac(arp_mac), .arp_ip(arp_ip),
    .payload_data(payload_data), .payload_rd(payload_rd), .tx_data(tx_data),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_src_rdy(tx_src_rdy),
    .tx_dst_rdy(tx_dst_rdy), .busy(busy), .done(done), .tx_error(tx_error)
  );

  int compared = 0;
  int mismatched = 0;

  // Each entry: {is_payload, sof_n, eof_n, data}
  logic [10:0] expQ[$];
  logic [7:0]  fb[0:1599];
  bit          fbPay[0:1599];
  int          fbLen, expTotal;

  logic [7:0]  payloadMem[0:1471];
  int          fifoIdx;
  logic [7:0]  rxFrame[0:1599];
  int          rxCount, payRd, doneCount, firstSrcK;
  logic [15:0] identModel;
  bit          curIsUdp;
  int          activity;

  assign payload_data = payloadMem[(fifoIdx < 1472) ? fifoIdx : 0];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic putField(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      fb[fbLen] = v[8*i +: 8];
      fbPay[fbLen] = 1'b0;
      fbLen++;
    end
  endtask

  task automatic commitFrame();
    while (fbLen < 60) begin
      fb[fbLen] = 8'h00;
      fbPay[fbLen] = 1'b0;
      fbLen++;
    end
    expTotal = fbLen;
    for (int i = 0; i < fbLen; i++)
      expQ.push_back({fbPay[i], (i == 0) ? 1'b0 : 1'b1, (i == fbLen - 1) ? 1'b0 : 1'b1, fb[i]});
  endtask

  task automatic buildUdp(input logic [47:0] mac, input logic [31:0] ip,
                          input logic [15:0] port, input int n);
    logic [15:0] tl, ul, cs;
    logic [31:0] sum;
    tl = 16'(28 + n);
    ul = 16'(8 + n);
    sum = 32'h4500 + 32'(tl) + 32'(identModel) + 32'({TTL, 8'h11})
        + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) + 32'(ip[31:16]) + 32'(ip[15:0]);
    sum = 32'(sum[15:0]) + 32'(sum[31:16]);
    sum = 32'(sum[15:0]) + 32'(sum[31:16]);
    cs = ~sum[15:0];
    fbLen = 0;
    putField(64'(mac), 6);      putField(64'(SRC_MAC), 6);
    putField(64'h0800, 2);      putField(64'h4500, 2);
    putField(64'(tl), 2);       putField(64'(identModel), 2);
    putField(64'h0, 2);         putField(64'({TTL, 8'h11}), 2);
    putField(64'(cs), 2);       putField(64'(SRC_IP), 4);
    putField(64'(ip), 4);       putField(64'(SRC_PORT), 2);
    putField(64'(port), 2);     putField(64'(ul), 2);
    putField(64'h0, 2);
    for (int i = 0; i < n; i++) begin
      fb[fbLen] = payloadMem[i];
      fbPay[fbLen] = 1'b1;
      fbLen++;
    end
    commitFrame();
  endtask

  task automatic buildArp(input logic [47:0] amac, input logic [31:0] aip);
    fbLen = 0;
    putField(64'(amac), 6);     putField(64'(SRC_MAC), 6);
    putField(64'h0806, 2);      putField(64'h0001080006040002, 8);
    putField(64'(SRC_MAC), 6);  putField(64'(SRC_IP), 4);
    putField(64'(amac), 6);     putField(64'(aip), 4);
    commitFrame();
  endtask

  task automatic applyStimulus(input bit udp, input bit arp, input logic [47:0] mac,
                               input logic [31:0] ip, input logic [15:0] port, input int len,
                               input logic [47:0] amac, input logic [31:0] aip);
    @(negedge clk);
    dst_mac = mac; dst_ip = ip; dst_port = port; payload_len = 11'(len);
    arp_mac = amac; arp_ip = aip;
    send_udp = udp; send_arp = arp;
    fifoIdx = 0;
    if (arp) begin
      buildArp(amac, aip);
      curIsUdp = 1'b0;
    end else if (udp && len <= 1472) begin
      buildUdp(mac, ip, port, len);
      curIsUdp = 1'b1;
    end
    @(negedge clk);
    send_udp = 1'b0; send_arp = 1'b0;
  endtask

  task automatic runFrame(input int stallPct, input int maxCycles, input int stopAfter,
                          input bit busyPoke);
    int k;
    bit finished, prevDone, pop;
    logic [10:0] head;
    k = 0; finished = 0; prevDone = 0;
    rxCount = 0; payRd = 0; doneCount = 0; firstSrcK = 0;
    while (!finished && k < maxCycles) begin
      k++;
      pop = 0;
      tx_dst_rdy = (stallPct > 0) && ($urandom_range(99) < stallPct);
      send_udp = busyPoke && (k == 10);
      #1;
      if (prevDone) begin
        checkOutput("busyAfterDone", 64'(busy), 64'(0));
        checkOutput("doneWidth", 64'(done), 64'(0));
        finished = 1;
      end
      if (!tx_src_rdy) begin
        if (firstSrcK == 0) firstSrcK = k;
        if (expQ.size() == 0) begin
          checkOutput("frameLen", 64'(rxCount + 1), 64'(expTotal));
        end else begin
          head = expQ[0];
          if (!tx_dst_rdy) begin
            checkOutput("byte", 64'({payload_rd, tx_sof, tx_eof, tx_data}), 64'(head));
            void'(expQ.pop_front());
            if (rxCount < 1600) rxFrame[rxCount] = tx_data;
            rxCount++;
          end else begin
            checkOutput("stallHold", 64'({payload_rd, tx_sof, tx_eof, tx_data}),
                        64'({1'b0, head[9:0]}));
          end
        end
      end
      if (payload_rd) begin
        payRd++;
        pop = 1;
      end
      if (done && !prevDone) begin
        doneCount++;
        checkOutput("busyAtDone", 64'(busy), 64'(1));
        prevDone = 1;
        if (curIsUdp) identModel++;
      end
      if (stopAfter > 0 && rxCount >= stopAfter) finished = 1;
      @(posedge clk);
      #1;
      if (pop) fifoIdx++;
      @(negedge clk);
    end
    send_udp = 1'b0;
    tx_dst_rdy = 1'b0;
  endtask

  task automatic finishFrame(input int expPayRd);
    checkOutput("doneCount", 64'(doneCount), 64'(1));
    checkOutput("queueEmpty", 64'(expQ.size()), 64'(0));
    checkOutput("latency", 64'(firstSrcK), 64'(4));
    checkOutput("payloadRdCount", 64'(payRd), 64'(expPayRd));
    checkOutput("frameBytes", 64'(rxCount), 64'(expTotal));
  endtask

  task automatic idleCheck(input int n, output int act);
    act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (!tx_src_rdy || tx_error || busy || payload_rd) act++;
    end
  endtask

  initial begin
    reset = 1'b0;
    send_udp = 0; send_arp = 0; dst_mac = '0; dst_ip = '0; dst_port = '0;
    payload_len = '0; arp_mac = '0; arp_ip = '0; tx_dst_rdy = 1'b0;
    identModel = '0; curIsUdp = 0; fifoIdx = 0; expTotal = 0;
    for (int i = 0; i < 1472; i++) payloadMem[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetOutputs",
                64'({tx_src_rdy, tx_sof, tx_eof, tx_data, payload_rd, busy, done, tx_error}),
                64'({1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    reset = 1'b1;

    // Basic short UDP frame, padded to 60 bytes
    applyStimulus(1, 0, 48'h021122334455, 32'hA9FEF299, 16'h11D2, 6, '0, '0);
    runFrame(0, 200, 0, 0);
    finishFrame(6);
    checkOutput("udpEtherType", 64'({rxFrame[12], rxFrame[13]}), 64'h0800);
    checkOutput("udpTotalLen",  64'({rxFrame[16], rxFrame[17]}), 64'h0022);
    checkOutput("udpIdent0",    64'({rxFrame[18], rxFrame[19]}), 64'h0000);
    checkOutput("udpHdrCsum",   64'({rxFrame[24], rxFrame[25]}), 64'h419C);
    checkOutput("udpLen",       64'({rxFrame[38], rxFrame[39]}), 64'h000E);

    // ARP reply
    applyStimulus(0, 1, '0, '0, '0, 0, 48'h242424242424, 32'hA9FEF299);
    runFrame(0, 200, 0, 0);
    finishFrame(0);
    checkOutput("arpFixed", 64'({rxFrame[12], rxFrame[13], rxFrame[14], rxFrame[15],
                                 rxFrame[16], rxFrame[17], rxFrame[18], rxFrame[19]}),
                64'h0806000108000604);
    checkOutput("arpOper", 64'({rxFrame[20], rxFrame[21]}), 64'h0002);
    checkOutput("arpTgtMac", 64'({rxFrame[32], rxFrame[33], rxFrame[34], rxFrame[35],
                                  rxFrame[36], rxFrame[37]}), 64'h242424242424);
    checkOutput("arpTgtIp", 64'({rxFrame[38], rxFrame[39], rxFrame[40], rxFrame[41]}),
                64'hA9FEF299);

    // Random backpressure during a 100-byte payload
    applyStimulus(1, 0, 48'h0A1B2C3D4E5F, 32'hA9FEF299, 16'h1234, 100, '0, '0);
    runFrame(50, 2000, 0, 0);
    finishFrame(100);
    checkOutput("bpIdent", 64'({rxFrame[18], rxFrame[19]}), 64'h0001);

    // Simultaneous requests: ARP wins; a request while busy is dropped
    applyStimulus(1, 1, 48'h0A1B2C3D4E5F, 32'hC0A80002, 16'h2222, 20,
                  48'h0A0B0C0D0E0F, 32'hC0A80001);
    runFrame(0, 200, 0, 1);
    finishFrame(0);
    checkOutput("dualIsArp", 64'({rxFrame[12], rxFrame[13]}), 64'h0806);
    idleCheck(12, activity);
    checkOutput("pokeIgnored", 64'(activity), 64'(0));

    // Oversize request rejected, then the maximum legal payload
    applyStimulus(1, 0, 48'h0A1B2C3D4E5F, 32'hA9FEF299, 16'h11D2, 1473, '0, '0);
    checkOutput("txErrorPulse", 64'({tx_error, busy}), 64'({1'b1, 1'b0}));
    idleCheck(10, activity);
    checkOutput("rejectQuiet", 64'(activity), 64'(0));
    applyStimulus(1, 0, 48'h0A1B2C3D4E5F, 32'hA9FEF299, 16'h11D2, 1472, '0, '0);
    runFrame(0, 3000, 0, 0);
    finishFrame(1472);
    checkOutput("maxTotalLen", 64'({rxFrame[16], rxFrame[17]}), 64'h05DC);

    // Reset in the middle of a frame
    applyStimulus(1, 0, 48'h021122334455, 32'hA9FEF299, 16'h11D2, 30, '0, '0);
    runFrame(0, 200, 20, 0);
    reset = 1'b0;
    #1;
    checkOutput("midReset", 64'({tx_src_rdy, busy, tx_sof, tx_eof, payload_rd}),
                64'({1'b1, 1'b0, 1'b1, 1'b1, 1'b0}));
    expQ.delete();
    identModel = '0;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1, 0, 48'h021122334455, 32'hA9FEF299, 16'h11D2, 6, '0, '0);
    runFrame(0, 200, 0, 0);
    finishFrame(6);
    checkOutput("identAfterReset", 64'({rxFrame[18], rxFrame[19]}), 64'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
